// File: rtl/ext_mem_pkg.sv
// ============================================================================
// ext_mem_pkg : shared types and constants for the external memory arbiter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ext_mem_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        DONE   = 3'd3,
        TURN   = 3'd4
    } state_t;

    localparam logic TGT_SRAM   = 1'b0;
    localparam logic TGT_FLASH  = 1'b1;
    localparam int   WAIT_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/ext_mem_arbiter_rr.sv
// ============================================================================
// rr_arbiter : round-robin requester pick; pointer moves past the grant
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             CLK_40,
    input  logic             reset,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N)) begin
                w_sum = w_sum - (IDX_W+1)'(N);
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && req_i[w_idx]) begin
                w_found        = 1'b1;
                grant_o[w_idx] = 1'b1;
                grant_idx_o    = w_idx;
            end
        end
    end

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            if (grant_idx_o == IDX_W'(N - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= grant_idx_o + IDX_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ext_mem_arbiter.sv
// ============================================================================
// ext_mem_arbiter : round-robin sequencer for the shared SRAM / NOR flash bus
// Optional feature: FLASH_BUSY_WAIT_EN (hold flash ops in SETUP while busy)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module ext_mem_arbiter
    import ext_mem_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int ADDR_W     = 20,
    parameter int SRAM_WAIT  = 0,
    parameter int FLASH_WAIT = 3,
    parameter int TURN_CYC   = 1
) (
    input  logic                     CLK_40,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH-1:0]        ch_we_i,
    input  logic [NUM_CH-1:0]        ch_flash_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    input  logic [NUM_CH*8-1:0]      ch_wdata_i,
    output logic [NUM_CH-1:0]        ch_ack_o,
    output logic [7:0]               rd_data_o,
    output logic [ADDR_W-1:0]        ext_addr_o,
    inout  wire  [7:0]               ext_data_io,
    output logic                     mem_we_n_o,
    output logic                     sram_oe_n_o,
    output logic                     sram_bhe_n_o,
    output logic                     sram_ble_n_o,
    output logic                     flash_ce_n_o,
    output logic                     flash_oe_n_o,
    input  logic                     flash_ry_by_i
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [WAIT_CNT_W-1:0] c_sram_wait  = WAIT_CNT_W'(SRAM_WAIT);
    localparam logic [WAIT_CNT_W-1:0] c_flash_wait = WAIT_CNT_W'(FLASH_WAIT);
    localparam logic [WAIT_CNT_W-1:0] c_turn_last  = WAIT_CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]       grant_oh_q;
    logic                    we_q, fl_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [7:0]              wdata_q, rd_q;

    logic                    w_advance, w_stall, w_drive;
    logic [NUM_CH-1:0]       w_grant_oh;
    logic [IDX_W-1:0]        w_grant_idx;

    assign w_advance = (state_q == IDLE) && (|ch_req_i);

    rr_arbiter #(.N(NUM_CH), .IDX_W(IDX_W)) u_rr (
        .CLK_40      (CLK_40),
        .reset       (reset),
        .req_i       (ch_req_i),
        .advance_i   (w_advance),
        .grant_o     (w_grant_oh),
        .grant_idx_o (w_grant_idx)
    );

`ifdef FLASH_BUSY_WAIT_EN
    assign w_stall = (state_q == SETUP) && (fl_q == TGT_FLASH) && !flash_ry_by_i;
`else
    logic w_unused_ry;
    assign w_unused_ry = flash_ry_by_i;
    assign w_stall     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_ack_o     = '0;
        ext_addr_o   = '0;
        w_drive      = 1'b0;
        mem_we_n_o   = 1'b1;
        sram_oe_n_o  = 1'b1;
        sram_bhe_n_o = 1'b1;
        sram_ble_n_o = 1'b1;
        flash_ce_n_o = 1'b1;
        flash_oe_n_o = 1'b1;
        case (state_q)
            IDLE: begin
                if (|ch_req_i) state_d = SETUP;
            end
            SETUP, ACCESS: begin
                ext_addr_o = (fl_q == TGT_FLASH) ? addr_q : {1'b0, addr_q[ADDR_W-1:1]};
                w_drive    = we_q;
                if (fl_q == TGT_FLASH) begin
                    flash_ce_n_o = w_stall;
                end else begin
                    sram_ble_n_o = addr_q[0];
                    sram_bhe_n_o = ~addr_q[0];
                end
                if (state_q == SETUP) begin
                    if (!w_stall) begin
                        state_d = ACCESS;
                        cnt_d   = (fl_q == TGT_FLASH) ? c_flash_wait : c_sram_wait;
                    end
                end else begin
                    if (we_q)                    mem_we_n_o   = 1'b0;
                    else if (fl_q == TGT_FLASH)  flash_oe_n_o = 1'b0;
                    else                         sram_oe_n_o  = 1'b0;
                    if (cnt_q == '0) state_d = DONE;
                    else             cnt_d   = cnt_q - WAIT_CNT_W'(1);
                end
            end
            DONE: begin
                // Address and write data stay valid one cycle past the strobes for hold time.
                ext_addr_o = (fl_q == TGT_FLASH) ? addr_q : {1'b0, addr_q[ADDR_W-1:1]};
                w_drive    = we_q;
                ch_ack_o   = grant_oh_q;
                if (!we_q && (TURN_CYC != 0)) begin
                    state_d = TURN;
                    cnt_d   = c_turn_last;
                end else begin
                    state_d = IDLE;
                end
            end
            TURN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - WAIT_CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_oh_q <= '0;
            we_q       <= 1'b0;
            fl_q       <= TGT_SRAM;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_advance) begin
                grant_oh_q <= w_grant_oh;
                we_q       <= ch_we_i[w_grant_idx];
                fl_q       <= ch_flash_i[w_grant_idx];
                addr_q     <= ch_addr_i[w_grant_idx*ADDR_W +: ADDR_W];
                wdata_q    <= ch_wdata_i[w_grant_idx*8 +: 8];
            end
            if ((state_q == ACCESS) && (cnt_q == '0) && !we_q) begin
                rd_q <= ext_data_io;
            end
        end
    end

    assign ext_data_io = w_drive ? wdata_q : 8'hzz;
    assign rd_data_o   = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_ext_mem_arbiter.sv
// ============================================================================
// tb_ext_mem_arbiter : directed bench with a per-cycle transaction-level model
// Revision           : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_ext_mem_arbiter;

    localparam int SW = 0;
    localparam int FW = 3;
    localparam int TC = 1;

    logic        CLK_40 = 1'b0;
    logic        reset  = 1'b1;
    logic [3:0]  req = '0, we = '0, fl = '0;
    logic [79:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        ry    = 1'b1;
    wire  [3:0]  ack;
    wire  [7:0]  rd_data;
    wire  [19:0] ext_addr;
    wire  [7:0]  ext_data;
    wire         we_n, soe_n, bhe_n, ble_n, fce_n, foe_n;

    int checks = 0;
    int errors = 0;

    always #12.5 CLK_40 = ~CLK_40;

    ext_mem_arbiter #(
        .NUM_CH(4), .ADDR_W(20), .SRAM_WAIT(SW), .FLASH_WAIT(FW), .TURN_CYC(TC)
    ) dut (
        .CLK_40        (CLK_40),
        .reset         (reset),
        .ch_req_i      (req),
        .ch_we_i       (we),
        .ch_flash_i    (fl),
        .ch_addr_i     (addr),
        .ch_wdata_i    (wdata),
        .ch_ack_o      (ack),
        .rd_data_o     (rd_data),
        .ext_addr_o    (ext_addr),
        .ext_data_io   (ext_data),
        .mem_we_n_o    (we_n),
        .sram_oe_n_o   (soe_n),
        .sram_bhe_n_o  (bhe_n),
        .sram_ble_n_o  (ble_n),
        .flash_ce_n_o  (fce_n),
        .flash_oe_n_o  (foe_n),
        .flash_ry_by_i (ry)
    );

    // Board-side memories: the floating bus reads back as 0xFF.
    logic [7:0] sram_bus [64];
    logic [7:0] flash_bus [64];
    logic [7:0] sram_mdl [64];
    logic [7:0] flash_mdl [64];
    wire        mem_rd_en = !soe_n || !foe_n;
    wire  [7:0] mem_rd_val = !soe_n ? sram_bus[{ext_addr[4:0], ble_n}] : flash_bus[ext_addr[5:0]];
    assign ext_data = mem_rd_en ? mem_rd_val : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup pu (ext_data[i]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_40);
        #1;
    endtask

    // Transaction-level model: each op is a timeline of IDLE-grant, SETUP, ACCESS x(1+W), DONE, TURN.
    int          m_k = 0, m_last = 0, m_w = 0, m_g = 0, m_ptr = 0;
    logic        m_busy = 1'b0, m_we = 1'b0, m_fl = 1'b0, m_found;
    logic [19:0] m_a = '0;
    logic [7:0]  m_d = '0, m_rd = '0;

    initial begin
        logic ph_setup, ph_acc, ph_done, stl, drv;
        logic [19:0] e_addr;
        forever begin
            @(negedge CLK_40);
            if (!we_n) begin
                if (!fce_n) flash_bus[ext_addr[5:0]]     = ext_data;
                else        sram_bus[{ext_addr[4:0], ble_n}] = ext_data;
            end
            if (reset) begin
                m_busy = 1'b0;
                m_ptr  = 0;
                m_rd   = '0;
            end else begin
                if (m_busy) begin
                    m_k++;
                    if (m_k > m_last) m_busy = 1'b0;
                end
                if (!m_busy && (req != 4'b0)) begin
                    m_found = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        if (!m_found && req[(m_ptr + i) % 4]) begin
                            m_found = 1'b1;
                            m_g     = (m_ptr + i) % 4;
                        end
                    end
                    m_we   = we[m_g];
                    m_fl   = fl[m_g];
                    m_a    = addr[m_g*20 +: 20];
                    m_d    = wdata[m_g*8 +: 8];
                    m_w    = m_fl ? FW : SW;
                    m_last = 3 + m_w + (m_we ? 0 : TC);
                    m_k    = 0;
                    m_busy = 1'b1;
                    m_ptr  = (m_g + 1) % 4;
                end
            end
            ph_setup = m_busy && (m_k == 1);
            ph_acc   = m_busy && (m_k >= 2) && (m_k <= 2 + m_w);
            ph_done  = m_busy && (m_k == 3 + m_w);
`ifdef FLASH_BUSY_WAIT_EN
            stl = ph_setup && m_fl && !ry;
`else
            stl = 1'b0;
`endif
            if (ph_done) begin
                if (m_we) begin
                    if (m_fl) flash_mdl[m_a[5:0]] = m_d;
                    else      sram_mdl[m_a[5:0]]  = m_d;
                end else begin
                    m_rd = m_fl ? flash_mdl[m_a[5:0]] : sram_mdl[m_a[5:0]];
                end
            end
            drv    = m_we && (ph_setup || ph_acc || ph_done);
            e_addr = (ph_setup || ph_acc || ph_done) ? (m_fl ? m_a : (m_a >> 1)) : 20'h0;
            chk("m_ack", {28'h0, ack}, ph_done ? (32'h1 << m_g) : 32'h0);
            chk("m_addr", {12'h0, ext_addr}, {12'h0, e_addr});
            chk("m_rd_data", {24'h0, rd_data}, {24'h0, m_rd});
            chk("m_strobes", {26'h0, we_n, soe_n, foe_n, fce_n, bhe_n, ble_n},
                {26'h0,
                 !(ph_acc && m_we),
                 !(ph_acc && !m_we && !m_fl),
                 !(ph_acc && !m_we && m_fl),
                 !(((ph_setup && !stl) || ph_acc) && m_fl),
                 ((ph_setup || ph_acc) && !m_fl) ? ~m_a[0] : 1'b1,
                 ((ph_setup || ph_acc) && !m_fl) ?  m_a[0] : 1'b1});
            if (drv)                     chk("m_wdata", {24'h0, ext_data}, {24'h0, m_d});
            else if (!(ph_acc && !m_we)) chk("m_bus_release", {24'h0, ext_data}, 32'hFF);
            if (stl) m_k--;
        end
    end

    int          n_we, n_oe;
    logic [19:0] s_addr;
    logic        s_ble, s_bhe;

    task automatic do_op(input int ch, input logic w, input logic f, input logic [19:0] a,
                         input logic [7:0] d, output int lat);
        we[ch] = w;
        fl[ch] = f;
        addr[ch*20 +: 20] = a;
        wdata[ch*8 +: 8]  = d;
        req[ch] = 1'b1;
        lat  = -1;
        n_we = 0;
        n_oe = 0;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            @(negedge CLK_40);
            if (c == 1) begin
                s_addr = ext_addr;
                s_ble  = ble_n;
                s_bhe  = bhe_n;
            end
            if (!we_n) n_we++;
            if (!soe_n || !foe_n) n_oe++;
            if (ack[ch]) lat = c;
        end
        tick();
        req[ch] = 1'b0;
    endtask

    initial begin
        int lat, nack, last_c, first_ch;
        int seq [5];
        for (int i = 0; i < 64; i++) begin
            sram_bus[i]  = 8'h40 + 8'(i);
            sram_mdl[i]  = 8'h40 + 8'(i);
            flash_bus[i] = 8'h80 + 8'(i);
            flash_mdl[i] = 8'h80 + 8'(i);
        end
        sram_bus[4] = 8'h3C;
        sram_mdl[4] = 8'h3C;

        repeat (3) tick();
        chk("rst_ack", {28'h0, ack}, 32'h0);
        chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
        chk("rst_addr", {12'h0, ext_addr}, 32'h0);
        chk("rst_strobes", {26'h0, we_n, soe_n, bhe_n, ble_n, fce_n, foe_n}, 32'h3F);
        chk("rst_bus", {24'h0, ext_data}, 32'hFF);
        reset = 1'b0;
        repeat (2) tick();

        do_op(0, 1'b1, 1'b0, 20'h00005, 8'hA5, lat);
        chk("t1_lat", lat, 3);
        chk("t1_addr", {12'h0, s_addr}, 32'h2);
        chk("t1_ble_bhe", {30'h0, s_ble, s_bhe}, 32'h2);
        chk("t1_we_cycles", n_we, 1);
        repeat (2) tick();

        do_op(1, 1'b0, 1'b0, 20'h00004, 8'h00, lat);
        chk("t2_lat", lat, 3);
        chk("t2_rd_data", {24'h0, rd_data}, 32'h3C);
        chk("t2_oe_cycles", n_oe, 1);
        do_op(0, 1'b1, 1'b0, 20'h00010, 8'h5A, lat);
        chk("t2_turn_lat", lat, 4);
        repeat (2) tick();

        do_op(3, 1'b0, 1'b0, 20'h00005, 8'h00, lat);
        chk("readback_rd", {24'h0, rd_data}, 32'hA5);
        repeat (3) tick();

        for (int i = 0; i < 4; i++) begin
            we[i] = 1'b1;
            fl[i] = 1'b0;
            addr[i*20 +: 20] = 20'h20 + 20'(i);
            wdata[i*8 +: 8]  = 8'h10 + 8'(i);
        end
        req = 4'hF;
        nack = 0;
        last_c = -1;
        for (int c = 0; c < 60 && nack < 5; c++) begin
            @(negedge CLK_40);
            chk("t3_ack_onehot", ($countones(ack) <= 1) ? 32'h1 : 32'h0, 32'h1);
            for (int i = 0; i < 4; i++) begin
                if (ack[i] && nack < 5) begin
                    seq[nack] = i;
                    nack++;
                    last_c = c;
                end
            end
        end
        tick();
        req = 4'h0;
        chk("t3_ack_count", nack, 5);
        chk("t3_order", {seq[0][7:0], seq[1][7:0], seq[2][7:0], seq[3][7:0]}, 32'h00010203);
        chk("t3_order5", seq[4], 0);
        chk("t3_last_ack_cycle", last_c, 19);
        repeat (3) tick();

        do_op(2, 1'b0, 1'b1, 20'hFFFFF, 8'h00, lat);
        chk("t4_lat", lat, 6);
        chk("t4_oe_cycles", n_oe, 4);
        chk("t4_addr", {12'h0, s_addr}, 32'hFFFFF);
        chk("t4_rd_data", {24'h0, rd_data}, 32'hBF);
        repeat (3) tick();

`ifdef FLASH_BUSY_WAIT_EN
        fork
            do_op(2, 1'b0, 1'b1, 20'hFFFFF, 8'h00, lat);
            begin
                tick();
                ry = 1'b0;
                repeat (10) tick();
                ry = 1'b1;
            end
        join
        chk("t5_lat", lat, 16);
        chk("t5_rd_data", {24'h0, rd_data}, 32'hBF);
        repeat (3) tick();
`endif

        we[2] = 1'b1;
        fl[2] = 1'b0;
        addr[40 +: 20] = 20'h00030;
        wdata[16 +: 8] = 8'h77;
        req[2] = 1'b1;
        tick();
        tick();
        chk("t6_in_access", {31'h0, we_n}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_strobes", {26'h0, we_n, soe_n, bhe_n, ble_n, fce_n, foe_n}, 32'h3F);
        chk("t6_bus", {24'h0, ext_data}, 32'hFF);
        chk("t6_ack", {28'h0, ack}, 32'h0);
        req[2] = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 1; i < 4; i += 2) begin
            we[i] = 1'b1;
            addr[i*20 +: 20] = 20'h30 + 20'(i);
            wdata[i*8 +: 8]  = 8'hE0 + 8'(i);
        end
        req = 4'b1010;
        first_ch = -1;
        for (int c = 0; c < 20 && first_ch < 0; c++) begin
            @(negedge CLK_40);
            if (ack[1]) first_ch = 1;
            else if (ack[3]) first_ch = 3;
        end
        tick();
        if (first_ch >= 0) req[first_ch] = 1'b0;
        chk("t6_ptr_reset_first", first_ch, 1);
        lat = -1;
        for (int c = 0; c < 20 && lat < 0; c++) begin
            @(negedge CLK_40);
            if (ack[3]) lat = c;
        end
        tick();
        req = 4'h0;
        chk("t6_second_ack", (lat >= 0) ? 32'h1 : 32'h0, 32'h1);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
